// File: rtl/skid_buffer_d.sv
// Two-entry elastic stage with valid/ready on both sides.
// in_ready depends only on registered occupancy, so out_ready never reaches it combinationally.
//
// state | meaning
// ------+----------------------------------------------
// EMPTY | no word held, out_valid=0
// ONE   | head word in main, skid unused
// FULL  | head in main, younger word in skid, in_ready=0
module skid_buffer_d #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [N-1:0] main_q, skid_q;
    logic         in_fire, out_fire;
    logic         load_main_in, load_main_skid, load_skid_in;

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL) & reset;
    assign count     = state;
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_nxt    = FULL;
                    load_skid_in = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // skid is always younger than main, so it becomes the new head
                if (out_fire) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_skid_buffer_d.sv
// Directed and random-backpressure bench for skid_buffer_d at N=8,
// with a two-deep queue model of the expected buffer contents.
module tb_skid_buffer_d;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] mq[$];

    skid_buffer_d #(.N(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_vld"}, out_valid, (mq.size() != 0));
        chk({tag, "_cnt"}, count, mq.size());
        chk({tag, "_rdy"}, in_ready, (mq.size() != 2));
        if (mq.size() != 0) chk({tag, "_dat"}, out_data, mq[0]);
    endtask

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy, input string tag);
        logic fin, fout;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        fin  = iv && (mq.size() < 2);
        fout = ordy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (fout) void'(mq.pop_front());
        if (fin) mq.push_back(id);
        chk_model(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;

        // reset held with an active producer
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_vld", out_valid, 1'b0);
            chk("rst_dat", out_data, 8'h00);
            chk("rst_cnt", count, 2'd0);
            chk("rst_rdy", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rel_rdy", in_ready, 1'b1);

        // single word held, then drained
        cycle(1'b1, 8'h5A, 1'b0, "sw_load");
        chk("sw_dat", out_data, 8'h5A);
        chk("sw_cnt", count, 2'd1);
        repeat (3) begin
            cycle(1'b0, 8'hFF, 1'b0, "sw_hold");
            chk("sw_hdat", out_data, 8'h5A);
            chk("sw_hvld", out_valid, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b1, "sw_drain");
        chk("sw_dcnt", count, 2'd0);
        chk("sw_dvld", out_valid, 1'b0);

        // back-to-back streaming
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 8'(i), 1'b1, "str");
            chk("str_dat", out_data, 8'(i));
            chk("str_cnt", count, 2'd1);
            chk("str_rdy", in_ready, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b1, "str_drain");
        chk("str_dcnt", count, 2'd0);

        // stall absorbs one word into skid, release preserves order
        cycle(1'b1, 8'h11, 1'b1, "stl_a");
        chk("stl_a_dat", out_data, 8'h11);
        cycle(1'b1, 8'h22, 1'b0, "stl_b");
        chk("stl_b_cnt", count, 2'd2);
        chk("stl_b_rdy", in_ready, 1'b0);
        chk("stl_b_dat", out_data, 8'h11);
        cycle(1'b1, 8'h33, 1'b0, "stl_c");
        chk("stl_c_cnt", count, 2'd2);
        chk("stl_c_dat", out_data, 8'h11);
        cycle(1'b1, 8'h33, 1'b1, "rls_a");
        chk("rls_a_dat", out_data, 8'h22);
        chk("rls_a_cnt", count, 2'd1);
        chk("rls_a_rdy", in_ready, 1'b1);
        cycle(1'b1, 8'h33, 1'b1, "rls_b");
        chk("rls_b_dat", out_data, 8'h33);
        chk("rls_b_cnt", count, 2'd1);
        cycle(1'b0, 8'h00, 1'b1, "rls_c");
        chk("rls_c_vld", out_valid, 1'b0);

        // random backpressure against the queue model
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 9) < 6), "rnd");
        end

        // drain, refill to FULL, then reset between edges
        cycle(1'b0, 8'h00, 1'b1, "pre_d0");
        cycle(1'b0, 8'h00, 1'b1, "pre_d1");
        chk("pre_cnt0", count, 2'd0);
        cycle(1'b1, 8'hC3, 1'b0, "pre_f0");
        cycle(1'b1, 8'h3C, 1'b0, "pre_f1");
        chk("pre_full", count, 2'd2);
        chk("pre_fdat", out_data, 8'hC3);
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        chk("mrst_vld", out_valid, 1'b0);
        chk("mrst_dat", out_data, 8'h00);
        chk("mrst_cnt", count, 2'd0);
        chk("mrst_rdy", in_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk("mrel_rdy", in_ready, 1'b1);
        chk("mrel_cnt", count, 2'd0);
        cycle(1'b1, 8'h77, 1'b1, "post");
        chk("post_dat", out_data, 8'h77);
        chk("post_cnt", count, 2'd1);
        cycle(1'b0, 8'h00, 1'b1, "post_d");
        chk("post_dvld", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/skid_buffer_d.md
# skid_buffer_d

Two-entry elastic register stage with a valid/ready handshake on both sides, parameterized in data width N. It sits directly upstream of the team's plain D register stage and feeds it. It decouples a producer from a consumer that can stall: it absorbs one extra word when the consumer deasserts ready, without a combinational path from out_ready to in_ready. All outputs are driven from registers.

## Interface
- N, default 1, data width in bits (N ≥ 1).

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  producer presents a word on in_data.
- in_ready  output  1  buffer can accept a word this cycle.
- in_data  input  N  producer data.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  N  head-of-buffer data.
- count  output  2  occupancy, 0 to 2.

## Operation
- Storage: main register (head, drives out_data) and skid register (second entry).
- Input transfer (in_fire) = in_valid & in_ready at a rising edge.
- Output transfer (out_fire) = out_valid & out_ready at a rising edge.
- FSM states: EMPTY (count=0), ONE (count=1), FULL (count=2).
- Decodes:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL) and reset deasserted.
  - count = state encoding 0/1/2.
- Transitions from EMPTY:
  - in_fire → ONE, main ← in_data.
  - otherwise stay in EMPTY.
- Transitions from ONE:
  - in_fire & out_fire → ONE, main ← in_data.
  - in_fire only → FULL, skid ← in_data.
  - out_fire only → EMPTY.
  - neither → ONE, hold.
- Transitions from FULL (in_ready=0, so no input transfer is possible):
  - out_fire → ONE, main ← skid.
  - otherwise hold.
- Ordering: strict FIFO. The word in skid is always younger than the word in main.
- in_data is ignored when in_valid=0. out_ready is ignored when out_valid=0.
- When EMPTY, out_data holds the last value in main (unchanged, not cleared). Benches must not check it while out_valid=0.
- No data is ever dropped or duplicated except on reset.

## Timing
- Reset (reset=0), asynchronous and immediate, not waiting for a clock edge:
  - state = EMPTY, main = 0, skid = 0.
  - out_valid=0, out_data=0, count=0, in_ready=0.
- After reset deasserts, in_ready=1 with no clock edge required. The first in_fire can occur at the first rising edge.
- Latency: a word accepted at edge k is on out_data with out_valid=1 immediately after edge k (1 cycle).
- Throughput: 1 word/cycle sustained while out_ready=1.
- in_ready depends only on registered state, never combinationally on out_ready. This is the purpose of the skid entry.
- Stall: if out_ready drops while the producer streams, one more word is absorbed (ONE → FULL) and in_ready falls after that edge.
- Release: the first out_fire in FULL moves skid to main, and in_ready rises after that edge.
- Reset mid-operation: both entries are discarded at once. Any transfer on the same edge that reset is low is ignored.
- Simultaneous in_fire and out_fire in ONE: occupancy is unchanged and main takes the new word the same edge the old one leaves.

## Test plan
- Reset: reset=0 with in_valid=1, in_data=8'hAA → out_valid=0, out_data=0, count=0, in_ready=0 throughout. After release, in_ready=1 before any edge.
- Single word (N=8): one-cycle in_valid with 8'h5A, out_ready=0 → after the edge out_valid=1, out_data=8'h5A, count=1. Hold for 3 cycles: unchanged. Then out_ready=1 for one edge → count=0, out_valid=0.
- Streaming: send 8'h01..8'h10 back-to-back with out_ready=1 → each word appears on out_data one cycle after acceptance, in order, in_ready never drops, count stays 1.
- Stall/skid: stream 8'h11, 8'h22, 8'h33 with out_ready=0 from the second edge → 8'h11 in main, 8'h22 in skid, count=2, in_ready=0, and 8'h33 is held by the producer. Raise out_ready → outputs 8'h11, then 8'h22, then 8'h33 with no loss or duplication.
- Random backpressure: 1000 cycles of random in_valid/out_ready → a scoreboard confirms output order equals input order, count matches the model, and in_ready=0 exactly when count=2.
- Mid-operation reset: in FULL with 8'hC3/8'h3C, pulse reset low between edges → outputs go to 0 immediately. After release, count=0 and the next accepted word 8'h77 is the first one output.
